// File: rtl/display_scan6.sv
// Purpose : six-digit HH:MM:SS BCD scanner driving one shared 7-segment bus plus per-digit anodes.
// Latency : seg/dp/an are registered, so they follow a digit-index change by one CP edge.
// Backpr. : none; EN=0 freezes prescaler, digit index, snapshot and outputs in place.
//
// Ports:
//   CP                 system clock, rising edge
//   nCR                asynchronous active-low reset (all digits dark)
//   EN                 scan enable
//   SecL/SecH/MinL/MinH/HrL/HrH   BCD digits from the counter chain
//   seg[6:0]           segments {g,f,e,d,c,b,a}, registered, polarity per SEG_ACTIVE_LOW
//   dp                 decimal point, registered, polarity per SEG_ACTIVE_LOW
//   an[5:0]            anode enables, an[i] = digit i, registered, polarity per AN_ACTIVE_LOW
//
// Build option: define LEADING_ZERO_BLANK_EN to blank the hours-tens digit when it is zero.
module display_scan6 #(
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       EN,
  input  logic [3:0] SecL,
  input  logic [3:0] SecH,
  input  logic [3:0] MinL,
  input  logic [3:0] MinH,
  input  logic [3:0] HrL,
  input  logic [3:0] HrH,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int            CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] PRESC_LAST = CW'(SCAN_DIV - 1);
  localparam logic          SEG_INV    = (SEG_ACTIVE_LOW != 0);
  localparam logic          AN_INV     = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]    SEG_OFF    = {7{SEG_INV}};
  localparam logic [5:0]    AN_OFF     = {6{AN_INV}};
  localparam logic [2:0]    IDX_LAST   = 3'd5;

  logic [CW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  // Snapshot layout: {HrH, HrL, MinH, MinL, SecH, SecL}
  logic [23:0]   snap_q, snap_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [5:0]    an_q, an_d;

  logic          tick;
  logic [3:0]    digit;
  logic [6:0]    seg_int;
  logic          dp_int;
  logic [5:0]    an_onehot;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;  // non-BCD codes show a dash
    endcase
    return s;
  endfunction

  assign tick = (presc_q == PRESC_LAST);

  // Digit currently being scanned, always taken from the frame snapshot.
  always_comb begin
    digit = 4'h0;
    case (idx_q)
      3'd0:    digit = snap_q[3:0];
      3'd1:    digit = snap_q[7:4];
      3'd2:    digit = snap_q[11:8];
      3'd3:    digit = snap_q[15:12];
      3'd4:    digit = snap_q[19:16];
      3'd5:    digit = snap_q[23:20];
      default: digit = 4'h0;
    endcase
  end

  // Active-high internal view of the segment/dp/anode pattern for idx_q.
  always_comb begin
    seg_int   = bcd_to_seg(digit);
    dp_int    = (idx_q == 3'd2) || (idx_q == 3'd4);
    an_onehot = 6'(1) << idx_q;
`ifdef LEADING_ZERO_BLANK_EN
    // Anode stays on so the scan duty per digit is unchanged; only the glyph is blanked.
    if ((idx_q == IDX_LAST) && (snap_q[23:20] == 4'h0)) begin
      seg_int = 7'h00;
      dp_int  = 1'b0;
    end
`endif
  end

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    an_d    = an_q;
    if (EN) begin
      if (tick) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        // Capture only at the frame boundary so a counter rollover never splits a frame.
        if (idx_q == IDX_LAST) begin
          snap_d = {HrH, HrL, MinH, MinL, SecH, SecL};
        end
      end else begin
        presc_d = presc_q + CW'(1);
      end
      seg_d = seg_int ^ SEG_OFF;
      dp_d  = dp_int ^ SEG_INV;
      an_d  = an_onehot ^ AN_OFF;
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
      snap_q  <= 24'h0;
      seg_q   <= SEG_OFF;
      dp_q    <= SEG_INV;
      an_q    <= AN_OFF;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_display_scan6.sv
// Purpose : directed bench for display_scan6 with SCAN_DIV=4, active-low segments and anodes.
// Latency : outputs sampled on the falling edge, half a cycle after the registering edge.
// Backpr. : EN is exercised as a freeze control; every wait on the DUT is cycle-bounded.
module tb_display_scan6;

  logic       CP = 1'b0;
  logic       nCR = 1'b0;
  logic       EN = 1'b0;
  logic [3:0] SecL, SecH, MinL, MinH, HrL, HrH;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [23:0] din;   // {HrH,HrL,MinH,MinL,SecH,SecL} driven mid-slot
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t tbl [12];

  display_scan6 #(
    .SCAN_DIV      (4),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .CP  (CP),
    .nCR (nCR),
    .EN  (EN),
    .SecL(SecL),
    .SecH(SecH),
    .MinL(MinL),
    .MinH(MinH),
    .HrL (HrL),
    .HrH (HrH),
    .seg (seg),
    .dp  (dp),
    .an  (an)
  );

  always #5 CP = ~CP;

  task automatic step();
    @(negedge CP);
    cyc++;
  endtask

  task automatic drive(input logic [23:0] d);
    {HrH, HrL, MinH, MinL, SecH, SecL} = d;
  endtask

  task automatic chk(input string name, input logic [5:0] ea, input logic [6:0] es, input logic ed);
    checks++;
    if (an !== ea || seg !== es || dp !== ed) begin
      errors++;
      $display("FAIL %s (cycle %0d): got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
               name, cyc, an, seg, dp, ea, es, ed);
    end
  endtask

  task automatic wait_an(input logic [5:0] t, input int budget, input string name);
    int n;
    n = 0;
    step();
    while (an !== t && n < budget) begin
      step();
      n++;
    end
    if (an !== t) begin
      checks++;
      errors++;
      $display("FAIL %s: an=%h never reached expected %h within %0d cycles", name, an, t, budget);
    end
  endtask

  initial begin
    // Frame 0: snapshot still zero, so every digit shows '0' (~3F = 40).
    tbl[0]  = '{24'h000000, 6'h3E, 7'h40, 1'b1};
    tbl[1]  = '{24'h000000, 6'h3D, 7'h40, 1'b1};
    tbl[2]  = '{24'h123456, 6'h3B, 7'h40, 1'b0};
    tbl[3]  = '{24'h123456, 6'h37, 7'h40, 1'b1};
    tbl[4]  = '{24'h123456, 6'h2F, 7'h40, 1'b0};
    tbl[5]  = '{24'h123456, 6'h1F, 7'h40, 1'b1};
    // Frame 1: 12:34:56 captured at end of frame 0; SecL changed to 7 mid-frame must not show.
    tbl[6]  = '{24'h123456, 6'h3E, 7'h02, 1'b1};  // SecL 6 -> ~7D
    tbl[7]  = '{24'h123456, 6'h3D, 7'h12, 1'b1};  // SecH 5 -> ~6D
    tbl[8]  = '{24'h123457, 6'h3B, 7'h19, 1'b0};  // MinL 4 -> ~66
    tbl[9]  = '{24'h123457, 6'h37, 7'h30, 1'b1};  // MinH 3 -> ~4F
    tbl[10] = '{24'h123457, 6'h2F, 7'h24, 1'b0};  // HrL  2 -> ~5B
    tbl[11] = '{24'h123457, 6'h1F, 7'h79, 1'b1};  // HrH  1 -> ~06

    drive(24'h000000);
    EN  = 1'b1;
    nCR = 1'b0;
    repeat (3) @(negedge CP);
    chk("reset_init", 6'h3F, 7'h7F, 1'b1);

    // Scan order, slot length, snapshot timing and frame-0 zeros.
    nCR = 1'b1;
    cyc = 0;
    for (int s = 1; s <= 48; s++) begin
      int j;
      step();
      j = (s - 1) / 4;
      chk($sformatf("scan_f%0d_slot%0d", j / 6, j % 6), tbl[j].an, tbl[j].seg, tbl[j].dp);
      if ((s - 1) % 4 == 1) drive(tbl[j].din);
    end

    // Frame 2 picks up SecL=7; HrH changed mid-frame stays old until frame 3.
    step();
    chk("new_frame_secl7", 6'h3E, 7'h78, 1'b1);
    while (cyc < 57) step();
    drive(24'h223457);
    while (cyc < 69) step();
    chk("no_tear_hrh", 6'h1F, 7'h79, 1'b1);
    while (cyc < 93) step();
    chk("hrh_next_frame", 6'h1F, 7'h24, 1'b1);

    // EN freeze during idx 3, then resume with the remaining prescaler count.
    while (cyc < 110) step();
    chk("pre_freeze", 6'h37, 7'h30, 1'b1);
    EN = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("freeze_hold", 6'h37, 7'h30, 1'b1);
    end
    EN = 1'b1;
    step();
    chk("resume_1", 6'h37, 7'h30, 1'b1);
    step();
    chk("resume_2", 6'h37, 7'h30, 1'b1);
    step();
    chk("resume_advance", 6'h2F, 7'h24, 1'b0);

    // Non-BCD minute units and zero hours tens.
    drive(24'h023B57);
    wait_an(6'h3B, 64, "wait_minl_slot");
    chk("invalid_bcd_dash", 6'h3B, 7'h3F, 1'b0);
    wait_an(6'h1F, 64, "wait_hrh_slot");
`ifdef LEADING_ZERO_BLANK_EN
    chk("hrh_zero_blank", 6'h1F, 7'h7F, 1'b1);
`else
    chk("hrh_zero_shown", 6'h1F, 7'h40, 1'b1);
`endif

    // Asynchronous reset mid-cycle: dark at once, held, then frame 0 shows zeros.
    step();
    #2 nCR = 1'b0;
    #1 chk("reset_async", 6'h3F, 7'h7F, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("reset_hold", 6'h3F, 7'h7F, 1'b1);
    end
    nCR = 1'b1;
    cyc = 0;
    step();
    chk("post_reset_first", 6'h3E, 7'h40, 1'b1);
    while (cyc < 9) step();
    chk("post_reset_zero_minl", 6'h3B, 7'h40, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
